// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : gmii_tx_framer
// Description : Wraps an upstream byte stream into GMII transmit frames.
//               Each frame gets a 7-byte preamble and an SFD. Short frames are
//               zero-padded. The inter-frame gap is enforced after each frame.
//               An upstream underrun is flagged with tx_er and the rest of the
//               frame is drained.
//               Define GMII_TX_FCS_EN to append a CRC-32 FCS. Without it, the
//               upstream supplies its own FCS bytes.
// Revision    : 1.0 - initial release
// ============================================================================
// All GMII outputs are registered. The byte chosen in a given state
// appears on gmii_txd one cycle later. Because of this, the output stream
// runs exactly one cycle behind the state register.
module gmii_tx_framer #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_FRAME = 60
) (
    input  logic       tx_dclk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PRE   = 3'd1;
    localparam logic [2:0] c_ST_SFD   = 3'd2;
    localparam logic [2:0] c_ST_DATA  = 3'd3;
    localparam logic [2:0] c_ST_PAD   = 3'd4;
`ifdef GMII_TX_FCS_EN
    localparam logic [2:0] c_ST_FCS   = 3'd5;
`endif
    localparam logic [2:0] c_ST_IFG   = 3'd6;
    localparam logic [2:0] c_ST_DRAIN = 3'd7;

`ifdef GMII_TX_FCS_EN
    localparam logic [10:0] c_PAD_LEN = 11'(MIN_FRAME);
`else
    // The upstream FCS is part of the payload here, so the minimum grows by 4.
    localparam logic [10:0] c_PAD_LEN = 11'(MIN_FRAME + 4);
`endif

    // The IFG state lasts IFG_BYTES-1 cycles. The IDLE cycle and the first
    // PRE cycle add one more idle byte time each, because of the output lag.
    // Together they give IFG_BYTES idle cycles on the wire.
    localparam int                 c_IFG_W    = $clog2(IFG_BYTES + 1);
    localparam logic [c_IFG_W-1:0] c_IFG_LAST = c_IFG_W'(IFG_BYTES - 2);

    logic [2:0]         r_state;
    logic [2:0]         r_pre_cnt;
    logic [c_IFG_W-1:0] r_ifg_cnt;
    logic [10:0]        r_count;
    logic [7:0]         r_txd;
    logic               r_tx_en;
    logic               r_tx_er;
    logic               r_s_ready;
    logic [10:0]        w_count_inc;

`ifdef GMII_TX_FCS_EN
    logic [31:0] r_crc;
    logic [1:0]  r_fcs_idx;
    logic [31:0] w_crc_data;
    logic [31:0] w_crc_pad;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;

    // Reflected CRC-32 (poly 0x04C11DB7 reflected) advanced by one byte, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_crc_data = crc_byte(r_crc, s_data);
    assign w_crc_pad  = crc_byte(r_crc, 8'h00);
    assign w_fcs      = ~r_crc;
    assign w_fcs_byte = w_fcs[{r_fcs_idx, 3'b000} +: 8];
`endif

    // The byte counter saturates instead of wrapping, so long frames never look short
    assign w_count_inc = (r_count == 11'h7FF) ? r_count : (r_count + 11'd1);

    // Framing state machine; it also drives every registered output
    always_ff @(posedge tx_dclk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pre_cnt <= 3'd0;
            r_ifg_cnt <= '0;
            r_count   <= 11'd0;
            r_txd     <= 8'h00;
            r_tx_en   <= 1'b0;
            r_tx_er   <= 1'b0;
            r_s_ready <= 1'b0;
`ifdef GMII_TX_FCS_EN
            r_crc     <= 32'hFFFFFFFF;
            r_fcs_idx <= 2'd0;
`endif
        end else begin
            r_txd   <= 8'h00;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (s_valid) begin
                        r_state   <= c_ST_PRE;
                        r_pre_cnt <= 3'd0;
                    end
                end
                c_ST_PRE: begin
                    r_txd   <= 8'h55;
                    r_tx_en <= 1'b1;
                    if (r_pre_cnt == 3'd6) begin
                        r_state <= c_ST_SFD;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 3'd1;
                    end
                end
                c_ST_SFD: begin
                    r_txd     <= 8'hD5;
                    r_tx_en   <= 1'b1;
                    r_count   <= 11'd0;
                    r_s_ready <= 1'b1;
                    r_state   <= c_ST_DATA;
`ifdef GMII_TX_FCS_EN
                    r_crc     <= 32'hFFFFFFFF;
`endif
                end
                c_ST_DATA: begin
                    r_tx_en <= 1'b1;
                    if (s_valid) begin
                        r_txd   <= s_data;
                        r_count <= w_count_inc;
`ifdef GMII_TX_FCS_EN
                        r_crc   <= w_crc_data;
`endif
                        if (s_last) begin
                            r_s_ready <= 1'b0;
                            if (w_count_inc < c_PAD_LEN) begin
                                r_state <= c_ST_PAD;
                            end else begin
`ifdef GMII_TX_FCS_EN
                                r_state   <= c_ST_FCS;
                                r_fcs_idx <= 2'd0;
`else
                                r_state   <= c_ST_IFG;
                                r_ifg_cnt <= '0;
`endif
                            end
                        end
                    end else begin
                        // Underrun: poison the frame on the wire, then drop the rest of it
                        r_tx_er <= 1'b1;
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_PAD: begin
                    r_tx_en <= 1'b1;
                    r_count <= w_count_inc;
`ifdef GMII_TX_FCS_EN
                    r_crc   <= w_crc_pad;
`endif
                    if (w_count_inc == c_PAD_LEN) begin
`ifdef GMII_TX_FCS_EN
                        r_state   <= c_ST_FCS;
                        r_fcs_idx <= 2'd0;
`else
                        r_state   <= c_ST_IFG;
                        r_ifg_cnt <= '0;
`endif
                    end
                end
`ifdef GMII_TX_FCS_EN
                c_ST_FCS: begin
                    r_txd     <= w_fcs_byte;
                    r_tx_en   <= 1'b1;
                    r_fcs_idx <= r_fcs_idx + 2'd1;
                    if (r_fcs_idx == 2'd3) begin
                        r_state   <= c_ST_IFG;
                        r_ifg_cnt <= '0;
                    end
                end
`endif
                c_ST_DRAIN: begin
                    if (s_valid && s_last) begin
                        r_s_ready <= 1'b0;
                        r_state   <= c_ST_IFG;
                        r_ifg_cnt <= '0;
                    end
                end
                c_ST_IFG: begin
                    if (r_ifg_cnt == c_IFG_LAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_s_ready <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign gmii_txd   = r_txd;
    assign gmii_tx_en = r_tx_en;
    assign gmii_tx_er = r_tx_er;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gmii_tx_framer
// Description : Self-checking bench for gmii_tx_framer. A behavioural model
//               predicts each GMII frame from the payload. That model covers
//               preamble, padding and a CRC-32 computed MSB-first. The bench
//               compares the model against a log of the wire outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_framer;

    localparam int c_IFG = 12;
    localparam int c_MIN = 60;
`ifdef GMII_TX_FCS_EN
    localparam int c_PAD_T = c_MIN;
`else
    localparam int c_PAD_T = c_MIN + 4;
`endif

    typedef logic [7:0] bq_t[$];
    typedef bit         lq_t[$];

    logic       tx_dclk = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       s_ready;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;

    int checks = 0;
    int errors = 0;

    bit         logging = 1'b0;
    logic [7:0] log_txd[$];
    bit         log_en[$];
    bit         log_er[$];

    gmii_tx_framer #(
        .IFG_BYTES(c_IFG),
        .MIN_FRAME(c_MIN)
    ) u_dut (
        .tx_dclk   (tx_dclk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .gmii_txd  (gmii_txd),
        .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er)
    );

    always #4 tx_dclk = ~tx_dclk;

    // Record the wire once per cycle, away from the active edge
    always @(negedge tx_dclk) begin
        if (logging) begin
            log_txd.push_back(gmii_txd);
            log_en.push_back(gmii_tx_en);
            log_er.push_back(gmii_tx_er);
        end
    end

    // Standard CRC-32 in its non-reflected form: reverse each byte, shift MSB-first, reverse and invert the result
    function automatic logic [31:0] crc32_ref(bq_t m);
        logic [31:0] c;
        logic [31:0] r;
        logic [7:0]  rb;
        logic [7:0]  cur;
        c = 32'hFFFFFFFF;
        foreach (m[k]) begin
            cur = m[k];
            for (int b = 0; b < 8; b++) rb[b] = cur[7-b];
            c = c ^ {rb, 24'h000000};
            for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        for (int b = 0; b < 32; b++) r[b] = c[31-b];
        return ~r;
    endfunction

    // Expected wire bytes for one frame: preamble, SFD, payload padded with zeros, then FCS
    function automatic bq_t build_frame(bq_t d);
        bq_t f;
        bq_t body;
        logic [31:0] crc;
        body = d;
        while (body.size() < c_PAD_T) body.push_back(8'h00);
        for (int k = 0; k < 7; k++) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (body[k]) f.push_back(body[k]);
        crc = crc32_ref(body);
`ifdef GMII_TX_FCS_EN
        for (int b = 0; b < 4; b++) f.push_back(crc[8*b +: 8]);
`endif
        return f;
    endfunction

    function automatic int count_mism(int s, bq_t exp, int n);
        int m;
        m = 0;
        for (int k = 0; k < n; k++) begin
            if (s < 0 || s + k >= log_txd.size() || k >= exp.size()) m++;
            else if (log_txd[s+k] !== exp[k]) m++;
        end
        return m;
    endfunction

    task automatic clear_log();
        log_txd.delete();
        log_en.delete();
        log_er.delete();
        logging = 1'b1;
    endtask

    // Finds the first tx_en run at or after index 'from'. s=-1 if none; e is the first index after it.
    task automatic find_run(input int from, output int s, output int e);
        s = -1;
        e = -1;
        if (from >= 0) begin
            for (int k = from; k < log_en.size(); k++) begin
                if (s < 0 && log_en[k]) s = k;
                else if (s >= 0 && !log_en[k]) begin
                    e = k;
                    break;
                end
            end
            if (s >= 0 && e < 0) e = log_en.size();
        end
    endtask

    task automatic rand_frame(input int n, inout bq_t d, inout lq_t l);
        for (int k = 0; k < n; k++) begin
            d.push_back(8'($urandom));
            l.push_back(k == n - 1);
        end
    endtask

    // Streams bytes to the DUT. Valid drops for one cycle at index drop_at,
    // and the stream stops early at index abort_at.
    task automatic drive(input bq_t d, input lq_t l, input int drop_at, input int abort_at, output int acc);
        int  i;
        int  guard;
        bit  dropped;
        bit  aborted;
        i = 0; guard = 0; dropped = 0; aborted = 0;
        while (i < d.size() && guard < 5000) begin
            @(negedge tx_dclk);
            guard++;
            if (i == abort_at) begin
                aborted = 1;
                break;
            end
            if (i == drop_at && !dropped) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                dropped = 1;
            end else begin
                s_valid = 1'b1;
                s_data  = d[i];
                s_last  = l[i];
                if (s_ready) i++;
            end
        end
        if (!aborted) @(negedge tx_dclk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        acc = i;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge tx_dclk);
        checks++; if (gmii_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", gmii_tx_en); end
        checks++; if (gmii_tx_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er: got %b want 0", gmii_tx_er); end
        checks++; if (gmii_txd !== 8'h00) begin errors++; $display("FAIL reset_txd: got %h want 00", gmii_txd); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        rst = 1'b0;
        repeat (5) @(negedge tx_dclk);
        checks++; if (gmii_tx_en !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: tx_en=%b s_ready=%b want 0/0", gmii_tx_en, s_ready);
        end
    endtask

    task automatic test_frame_60();
        bq_t d; lq_t l; bq_t exp;
        int acc, s, e, bad, ers;
        for (int k = 0; k < 60; k++) begin d.push_back(8'(k)); l.push_back(k == 59); end
        exp = build_frame(d);
        clear_log();
        drive(d, l, -1, -1, acc);
        repeat (120) @(negedge tx_dclk);
        find_run(0, s, e);
        checks++; if (s < 0 || e - s != 72) begin errors++; $display("FAIL f60_len: got %0d want 72", e - s); end
        checks++; if (count_mism(s, exp, 72) != 0) begin errors++; $display("FAIL f60_bytes: %0d bytes differ from model", count_mism(s, exp, 72)); end
        bad = 0; ers = 0;
        for (int k = 0; k < c_IFG; k++) begin
            if (e < 0 || e + k >= log_en.size()) bad++;
            else if (log_en[e+k] || log_txd[e+k] !== 8'h00) bad++;
        end
        foreach (log_er[k]) if (log_er[k]) ers++;
        checks++; if (bad != 0) begin errors++; $display("FAIL f60_ifg: %0d non-idle cycles in gap, want 0", bad); end
        checks++; if (ers != 0) begin errors++; $display("FAIL f60_tx_er: got %0d er cycles want 0", ers); end
    endtask

    task automatic test_one_byte();
        bq_t d; lq_t l; bq_t exp;
        int acc, s, e;
        d.push_back(8'hAB); l.push_back(1'b1);
        exp = build_frame(d);
        clear_log();
        drive(d, l, -1, -1, acc);
        repeat (120) @(negedge tx_dclk);
        find_run(0, s, e);
        checks++; if (s < 0 || e - s != 72) begin errors++; $display("FAIL one_byte_len: got %0d want 72", e - s); end
        checks++; if (count_mism(s, exp, 72) != 0) begin errors++; $display("FAIL one_byte_bytes: %0d bytes differ from model", count_mism(s, exp, 72)); end
    endtask

    task automatic test_full_frame();
        bq_t d; lq_t l; bq_t exp;
        int acc, s, e;
        rand_frame(64, d, l);
        exp = build_frame(d);
        clear_log();
        drive(d, l, -1, -1, acc);
        repeat (120) @(negedge tx_dclk);
        find_run(0, s, e);
        checks++; if (s < 0 || e - s != exp.size()) begin errors++; $display("FAIL full64_len: got %0d want %0d", e - s, exp.size()); end
        checks++; if (count_mism(s, exp, exp.size()) != 0) begin errors++; $display("FAIL full64_bytes: %0d bytes differ from model", count_mism(s, exp, exp.size())); end
    endtask

    task automatic test_back_to_back();
        bq_t d1; lq_t l1; bq_t d2; lq_t l2; bq_t d; lq_t l; bq_t exp1; bq_t exp2;
        int acc, s1, e1, s2, e2;
        rand_frame($urandom_range(40, 90), d1, l1);
        rand_frame($urandom_range(1, 70), d2, l2);
        exp1 = build_frame(d1);
        exp2 = build_frame(d2);
        d = {d1, d2};
        l = {l1, l2};
        clear_log();
        drive(d, l, -1, -1, acc);
        repeat (150) @(negedge tx_dclk);
        find_run(0, s1, e1);
        find_run(e1, s2, e2);
        checks++; if (s1 < 0 || e1 - s1 != exp1.size()) begin errors++; $display("FAIL b2b_len1: got %0d want %0d", e1 - s1, exp1.size()); end
        checks++; if (count_mism(s1, exp1, exp1.size()) != 0) begin errors++; $display("FAIL b2b_bytes1: %0d bytes differ", count_mism(s1, exp1, exp1.size())); end
        checks++; if (s2 < 0 || s2 - e1 != c_IFG) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want %0d", s2 - e1, c_IFG); end
        checks++; if (s2 < 0 || e2 - s2 != exp2.size()) begin errors++; $display("FAIL b2b_len2: got %0d want %0d", e2 - s2, exp2.size()); end
        checks++; if (count_mism(s2, exp2, exp2.size()) != 0) begin errors++; $display("FAIL b2b_bytes2: %0d bytes differ", count_mism(s2, exp2, exp2.size())); end
    endtask

    task automatic test_underrun();
        bq_t d; lq_t l; bq_t exp;
        int acc, s, e, s2, e2, er_cnt, er_pos;
        rand_frame(100, d, l);
        exp = build_frame(d);
        clear_log();
        drive(d, l, 20, -1, acc);
        repeat (60) @(negedge tx_dclk);
        find_run(0, s, e);
        er_cnt = 0; er_pos = -1;
        foreach (log_er[k]) if (log_er[k]) begin er_cnt++; er_pos = k; end
        checks++; if (s < 0 || e - s != 29) begin errors++; $display("FAIL underrun_len: got %0d want 29", e - s); end
        checks++; if (er_cnt != 1) begin errors++; $display("FAIL underrun_er_cycles: got %0d want 1", er_cnt); end
        checks++; if (er_pos < 0 || er_pos != s + 28 || log_en[er_pos] !== 1'b1 || log_txd[er_pos] !== 8'h00) begin
            errors++; $display("FAIL underrun_er_beat: er at %0d want %0d with tx_en=1 txd=00", er_pos, s + 28);
        end
        checks++; if (count_mism(s, exp, 28) != 0) begin errors++; $display("FAIL underrun_prefix: %0d bytes differ", count_mism(s, exp, 28)); end
        checks++; if (acc != 100) begin errors++; $display("FAIL underrun_drain: accepted %0d want 100", acc); end
        find_run(e, s2, e2);
        checks++; if (s2 >= 0 || s_ready !== 1'b0) begin errors++; $display("FAIL underrun_after: extra run at %0d, s_ready=%b want none/0", s2, s_ready); end
    endtask

    task automatic test_reset_mid();
        bq_t d; lq_t l; bq_t d2; lq_t l2; bq_t exp;
        int acc, s, e;
        rand_frame(100, d, l);
        clear_log();
        drive(d, l, -1, 30, acc);
        #2 rst = 1'b1;
        #1;
        checks++; if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00 || gmii_tx_er !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: en=%b txd=%h er=%b rdy=%b want 0/00/0/0", gmii_tx_en, gmii_txd, gmii_tx_er, s_ready);
        end
        @(negedge tx_dclk);
        #1 rst = 1'b0;
        rand_frame($urandom_range(1, 90), d2, l2);
        exp = build_frame(d2);
        clear_log();
        drive(d2, l2, -1, -1, acc);
        repeat (120) @(negedge tx_dclk);
        find_run(0, s, e);
        checks++; if (s < 0 || e - s != exp.size()) begin errors++; $display("FAIL midreset_len: got %0d want %0d", e - s, exp.size()); end
        checks++; if (count_mism(s, exp, exp.size()) != 0) begin errors++; $display("FAIL midreset_bytes: %0d bytes differ", count_mism(s, exp, exp.size())); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            bq_t d; lq_t l; bq_t exp;
            int acc, s, e;
            rand_frame($urandom_range(1, 130), d, l);
            exp = build_frame(d);
            clear_log();
            drive(d, l, -1, -1, acc);
            repeat (200) @(negedge tx_dclk);
            find_run(0, s, e);
            checks++; if (s < 0 || e - s != exp.size()) begin errors++; $display("FAIL rand%0d_len: got %0d want %0d", f, e - s, exp.size()); end
            checks++; if (count_mism(s, exp, exp.size()) != 0) begin errors++; $display("FAIL rand%0d_bytes: %0d bytes differ (len %0d)", f, count_mism(s, exp, exp.size()), d.size()); end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame_60();
        test_one_byte();
        test_full_frame();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
